mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_pkg.sv | 35 +++
 rtl/mdio_master_if.sv | 32 +++
 rtl/mdio_master_mdc_gen.sv | 41 ++++
 rtl/mdio_master.sv | 133 +++++++++++++
 tb/tb_mdio_master.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared definitions for the clause-22 MDIO master.
//   - mdio_state_t : frame FSM state
//   - START_CODE / OP_WRITE / OP_READ : frame field codes
//   - field widths, preamble length and total frame length
// Optional feature macro: MDIO_PREAMBLE_SUPPRESS_EN (drops the 32-bit preamble,
// giving a 32-bit frame instead of 64).
package mdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_TA       = 3'd3,
        ST_DATA     = 3'd4
    } mdio_state_t;

    localparam logic [1:0] START_CODE = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] TA_WRITE   = 2'b10;

    localparam int ADDR_W        = 5;
    localparam int DATA_W        = 16;
    localparam int PREAMBLE_BITS = 32;
    localparam int HEADER_BITS   = 14;   // ST + OP + PHYAD + REGAD
    localparam int TA_BITS       = 2;
    localparam int BIT_CNT_W     = 5;    // widest phase is the 32-bit preamble

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam int FRAME_BITS = HEADER_BITS + TA_BITS + DATA_W;
`else
    localparam int FRAME_BITS = PREAMBLE_BITS + HEADER_BITS + TA_BITS + DATA_W;
`endif

endpackage

// File: rtl/mdio_master_if.sv
// mdio_master_if: host request/response signals plus the PHY-side MDC/MDIO pins.
//   master modport : used by mdio_master (drives busy/rd_*/mdc/mdio_o/mdio_oe)
//   slave modport  : used by the host/PHY side (drives requests and mdio_i)
// Handshake: a request is taken on a clock edge where (wren | rden) and busy=0;
// wren/rden are ignored while busy=1 and nothing is queued.
interface mdio_master_if;
    import mdio_pkg::*;

    logic [ADDR_W-1:0] phy_add;
    logic [ADDR_W-1:0] reg_add;
    logic [DATA_W-1:0] wr_data;
    logic              wren;
    logic              rden;
    logic              busy;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              mdc;
    logic              mdio_o;
    logic              mdio_oe;
    logic              mdio_i;

    modport master (
        input  phy_add, reg_add, wr_data, wren, rden, mdio_i,
        output busy, rd_data, rd_valid, mdc, mdio_o, mdio_oe
    );

    modport slave (
        output phy_add, reg_add, wr_data, wren, rden, mdio_i,
        input  busy, rd_data, rd_valid, mdc, mdio_o, mdio_oe
    );

endinterface

// File: rtl/mdio_master_mdc_gen.sv
// mdc_gen: MDC divider. One bit period is 2*CLK_DIV clk cycles, mdc low for
// the first CLK_DIV and high for the second.
//   clk, rst : system clock, synchronous active-high reset
//   en       : run the divider (held in reset state while low)
//   mdc      : registered management clock
//   rise     : high in the cycle whose closing edge raises mdc
//   fall     : high in the cycle whose closing edge ends the bit period
module mdc_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] FULL_LAST = 9'(2 * CLK_DIV - 1);

    logic [8:0] cnt;

    assign rise = en && (cnt == HALF_LAST);
    assign fall = en && (cnt == FULL_LAST);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else begin
            cnt <= fall ? 9'd0 : cnt + 9'd1;
            if (rise) begin
                mdc <= 1'b1;
            end else if (fall) begin
                mdc <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdio_master.sv
// mdio_master: clause-22 MDIO frame generator (read and write).
//   clk, rst : system clock, synchronous active-high reset
//   bus      : mdio_master_if.master (requests, busy, read result, MDC/MDIO pins)
//   state    : current frame FSM state, exported for observation
// Parameter CLK_DIV (2..255) is the MDC half-period in clk cycles.
// Optional macro MDIO_PREAMBLE_SUPPRESS_EN: frame starts directly at ST.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic           clk,
    input  logic           rst,
    mdio_master_if.master  bus,
    output mdio_state_t    state
);

    logic                  busy_r;
    logic                  rd_valid_r;
    logic                  mdio_o_r;
    logic                  mdio_oe_r;
    logic                  mdc_w;
    logic                  rise;
    logic                  fall;
    logic                  is_read;
    logic [DATA_W-1:0]     rd_data_r;
    logic [DATA_W-1:0]     rd_shift;
    logic [FRAME_BITS-1:0] frame_sr;
    logic [FRAME_BITS-1:0] frame_load;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    mdio_state_t           next_state;

    assign bus.busy     = busy_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.mdc      = mdc_w;
    assign bus.mdio_o   = mdio_o_r;
    assign bus.mdio_oe  = mdio_oe_r;

    mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (busy_r),
        .mdc  (mdc_w),
        .rise (rise),
        .fall (fall)
    );

    // Whole frame assembled at acceptance; wren wins when both strobes are high.
    // Read TA/DATA positions are filled with ones since mdio_oe is low there.
    always_comb begin
        logic [1:0]        op_sel;
        logic [1:0]        ta_sel;
        logic [DATA_W-1:0] data_sel;
        op_sel   = bus.wren ? OP_WRITE : OP_READ;
        ta_sel   = bus.wren ? TA_WRITE : 2'b11;
        data_sel = bus.wren ? bus.wr_data : '1;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        frame_load = {START_CODE, op_sel, bus.phy_add, bus.reg_add, ta_sel, data_sel};
`else
        frame_load = {{PREAMBLE_BITS{1'b1}}, START_CODE, op_sel, bus.phy_add,
                      bus.reg_add, ta_sel, data_sel};
`endif
    end

    // Phase sequencing on the shared bit counter; only acted on at a bit boundary.
    always_comb begin
        next_state = state;
        case (state)
            ST_PREAMBLE: if (bit_cnt == BIT_CNT_W'(PREAMBLE_BITS - 1)) next_state = ST_HEADER;
            ST_HEADER:   if (bit_cnt == BIT_CNT_W'(HEADER_BITS - 1))   next_state = ST_TA;
            ST_TA:       if (bit_cnt == BIT_CNT_W'(TA_BITS - 1))       next_state = ST_DATA;
            ST_DATA:     if (bit_cnt == BIT_CNT_W'(DATA_W - 1))        next_state = ST_IDLE;
            default:     next_state = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            mdio_o_r   <= 1'b1;
            mdio_oe_r  <= 1'b0;
            rd_data_r  <= '0;
            rd_shift   <= '0;
            frame_sr   <= '0;
            is_read    <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            rd_valid_r <= 1'b0;
            if (state == ST_IDLE) begin
                if (bus.wren || bus.rden) begin
                    is_read   <= !bus.wren;
                    busy_r    <= 1'b1;
                    mdio_o_r  <= frame_load[FRAME_BITS-1];
                    mdio_oe_r <= 1'b1;
                    frame_sr  <= {frame_load[FRAME_BITS-2:0], 1'b1};
                    bit_cnt   <= '0;
                    rd_shift  <= '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                    state     <= ST_HEADER;
`else
                    state     <= ST_PREAMBLE;
`endif
                end
            end else begin
                if (rise && is_read && state == ST_DATA) begin
                    rd_shift <= {rd_shift[DATA_W-2:0], bus.mdio_i};
                end
                // Pins change only at the bit boundary (mdc falling).
                if (fall) begin
                    state   <= next_state;
                    bit_cnt <= (next_state != state) ? '0 : bit_cnt + BIT_CNT_W'(1);
                    if (next_state == ST_IDLE) begin
                        busy_r    <= 1'b0;
                        mdio_o_r  <= 1'b1;
                        mdio_oe_r <= 1'b0;
                        if (is_read) begin
                            rd_data_r  <= rd_shift;
                            rd_valid_r <= 1'b1;
                        end
                    end else begin
                        mdio_o_r  <= frame_sr[FRAME_BITS-1];
                        frame_sr  <= {frame_sr[FRAME_BITS-2:0], 1'b1};
                        mdio_oe_r <= !(is_read && (next_state == ST_TA || next_state == ST_DATA));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: self-checking bench for mdio_master at CLK_DIV=2.
// Table of request vectors run back-to-back, each frame captured bit by bit
// and compared against a scoreboard entry; hand-written sequences cover the
// ignored mid-frame request and a reset in the middle of a read.
module tb_mdio_master;
    import mdio_pkg::*;

    localparam int CD = 2;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam int FB = 32;
`else
    localparam int FB = 64;
`endif
    localparam int LIMIT = FB * 2 * CD + 40;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [4:0]  phy;
        logic [4:0]  rega;
        logic [15:0] data;
        logic [15:0] resp;
        logic        poke;
        logic [1:0]  exp_op;
        logic        exp_rv;
    } vec_t;

    logic        clk;
    logic        rst;
    mdio_state_t dut_state;
    int          n_checks;
    int          n_fail;
    logic [15:0] last_rd;

    logic [FB-1:0] exp_q[$];
    logic [FB-1:0] exp_oe_q[$];
    logic [15:0]   exp_rd_q[$];
    logic          exp_rv_q[$];

    mdio_master_if bus_if ();

    mdio_master #(.CLK_DIV(CD)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_if),
        .state (dut_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // driver + monitor: issues one request at the current negedge and follows
    // the frame to the first idle cycle, leaving the bench at that negedge.
    task automatic run_frame(input vec_t v);
        logic [31:0]   tail;
        logic [31:0]   tail_mask;
        logic [FB-1:0] e_o;
        logic [FB-1:0] e_oe;
        logic [FB-1:0] got_o;
        logic [FB-1:0] got_oe;
        logic [FB-1:0] s_o;
        logic [FB-1:0] s_oe;
        logic          cur_o;
        logic          cur_oe;
        logic          mdc_bad;
        logic          hold_bad;
        int            rv_cnt;
        int            k;
        int            bi;
        int            ph;

        tail      = {2'b01, v.exp_op, v.phy, v.rega,
                     (v.exp_rv ? 2'b00 : 2'b10), (v.exp_rv ? 16'h0000 : v.data)};
        tail_mask = v.exp_rv ? {14'h3FFF, 18'h0} : 32'hFFFF_FFFF;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        e_o  = tail;
        e_oe = tail_mask;
`else
        e_o  = {32'hFFFF_FFFF, tail};
        e_oe = {32'hFFFF_FFFF, tail_mask};
`endif
        if (v.exp_rv) last_rd = v.resp;
        exp_q.push_back(e_o);
        exp_oe_q.push_back(e_oe);
        exp_rd_q.push_back(last_rd);
        exp_rv_q.push_back(v.exp_rv);

        bus_if.wren    = v.wr;
        bus_if.rden    = v.rd;
        bus_if.phy_add = v.phy;
        bus_if.reg_add = v.rega;
        bus_if.wr_data = v.data;
        @(posedge clk);
        @(negedge clk);
        bus_if.wren    = 1'b0;
        bus_if.rden    = 1'b0;
        bus_if.phy_add = ~v.phy;
        bus_if.reg_add = ~v.rega;
        bus_if.wr_data = ~v.data;

        got_o    = '0;
        got_oe   = '0;
        cur_o    = 1'b0;
        cur_oe   = 1'b0;
        mdc_bad  = 1'b0;
        hold_bad = 1'b0;
        rv_cnt   = 0;
        k        = 0;
        while (bus_if.busy === 1'b1 && k < LIMIT) begin
            ph = k % (2 * CD);
            bi = k / (2 * CD);
            if (ph == 0) begin
                cur_o  = bus_if.mdio_o;
                cur_oe = bus_if.mdio_oe;
                if (bi < FB) begin
                    got_o[FB-1-bi]  = cur_o;
                    got_oe[FB-1-bi] = cur_oe;
                end
                // PHY model: present the next response bit at each bit start
                if (v.rd && !v.wr && bi >= FB - 16 && bi < FB)
                    bus_if.mdio_i = v.resp[15-(bi-(FB-16))];
            end else if (bus_if.mdio_o !== cur_o || bus_if.mdio_oe !== cur_oe) begin
                hold_bad = 1'b1;
            end
            if (bus_if.mdc !== (ph >= CD)) mdc_bad = 1'b1;
            if (bus_if.rd_valid === 1'b1) rv_cnt++;
            bus_if.rden = v.poke && (k == 100);
            k++;
            @(negedge clk);
        end
        bus_if.rden   = 1'b0;
        bus_if.mdio_i = 1'b0;

        // scoreboard compare at the first idle cycle
        s_o  = exp_q.pop_front();
        s_oe = exp_oe_q.pop_front();
        check("busy_timeout", 64'(k < LIMIT), 64'd1);
        check("busy_len", 64'(k), 64'(FB * 2 * CD));
        check("frame_o", 64'(got_o & s_oe), 64'(s_o & s_oe));
        check("frame_oe", 64'(got_oe), 64'(s_oe));
        check("mdc_shape", 64'(mdc_bad), 64'd0);
        check("pin_hold", 64'(hold_bad), 64'd0);
        check("rv_while_busy", 64'(rv_cnt), 64'd0);
        check("rv_at_end", 64'(bus_if.rd_valid), 64'(exp_rv_q.pop_front()));
        check("rd_data", 64'(bus_if.rd_data), 64'(exp_rd_q.pop_front()));
        check("idle_lines", 64'({bus_if.mdc, bus_if.mdio_o, bus_if.mdio_oe}), 64'(3'b010));
    endtask

    vec_t vecs[6];

    initial begin
        logic        busy_seen;
        logic [15:0] rnd_resp;
        vec_t        tmp;

        n_checks = 0;
        n_fail   = 0;
        last_rd  = 16'h0000;
        rnd_resp = 16'($urandom_range(1, 16'hFFFF));

        //          wr    rd    phy    reg    data      resp      poke  op        rv
        vecs[0] = '{1'b1, 1'b0, 5'h0F, 5'h00, 16'h1100, 16'h0000, 1'b0, OP_WRITE, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 5'h0F, 5'h01, 16'h0000, 16'h796D, 1'b0, OP_READ,  1'b1};
        vecs[2] = '{1'b1, 1'b1, 5'h12, 5'h1B, 16'hA5C3, 16'hFFFF, 1'b0, OP_WRITE, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    16'($urandom_range(0, 16'hFFFF)), rnd_resp, 1'b0, OP_READ, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    16'($urandom_range(0, 16'hFFFF)), 16'h0000, 1'b0, OP_WRITE, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 5'h03, 5'h1F, 16'h8001, 16'h0000, 1'b1, OP_WRITE, 1'b0};

        // reset
        rst            = 1'b1;
        bus_if.wren    = 1'b0;
        bus_if.rden    = 1'b0;
        bus_if.phy_add = '0;
        bus_if.reg_add = '0;
        bus_if.wr_data = '0;
        bus_if.mdio_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_lines", 64'({bus_if.mdc, bus_if.mdio_o, bus_if.mdio_oe}), 64'(3'b010));
        check("rst_rd", 64'({bus_if.rd_valid, bus_if.rd_data}), 64'd0);
        check("rst_state", 64'(dut_state), 64'(ST_IDLE));

        // vectors, back-to-back
        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // the rden poke in the last frame must not have started another one
        busy_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.busy === 1'b1) busy_seen = 1'b1;
        end
        check("no_requeue", 64'(busy_seen), 64'd0);

        // reset in the middle of a read (bit 40, mdc high), request held during reset
        bus_if.rden    = 1'b1;
        bus_if.phy_add = 5'h0F;
        bus_if.reg_add = 5'h01;
        @(posedge clk);
        @(negedge clk);
        bus_if.rden = 1'b0;
        repeat (40 * 2 * CD + CD) @(negedge clk);
        check("mid_busy", 64'(bus_if.busy), 64'd1);
        rst         = 1'b1;
        bus_if.wren = 1'b1;
        @(negedge clk);
        check("mrst_busy", 64'(bus_if.busy), 64'd0);
        check("mrst_lines", 64'({bus_if.mdc, bus_if.mdio_o, bus_if.mdio_oe}), 64'(3'b010));
        check("mrst_rd", 64'({bus_if.rd_valid, bus_if.rd_data}), 64'd0);
        check("mrst_state", 64'(dut_state), 64'(ST_IDLE));
        rst         = 1'b0;
        bus_if.wren = 1'b0;
        last_rd     = 16'h0000;
        @(negedge clk);
        check("rst_req_dropped", 64'(bus_if.busy), 64'd0);

        tmp = '{1'b1, 1'b0, 5'h1A, 5'h05, 16'h3C5A, 16'h0000, 1'b0, OP_WRITE, 1'b0};
        run_frame(tmp);

        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
